// File: rtl/seg_score_display_pkg.sv
// Shared constants and helpers for the seven-segment score display.
package seg_score_display_pkg;

    localparam int unsigned BCD_W = 4;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Bit SEG_x set means segment x is lit; codes 10-15 are unreachable and stay dark.
    function automatic logic [6:0] seg_lut(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    seg_lut = 7'b0111111;
            4'd1:    seg_lut = 7'b0000110;
            4'd2:    seg_lut = 7'b1011011;
            4'd3:    seg_lut = 7'b1001111;
            4'd4:    seg_lut = 7'b1100110;
            4'd5:    seg_lut = 7'b1101101;
            4'd6:    seg_lut = 7'b1111101;
            4'd7:    seg_lut = 7'b0000111;
            4'd8:    seg_lut = 7'b1111111;
            4'd9:    seg_lut = 7'b1101111;
            default: seg_lut = 7'b0000000;
        endcase
    endfunction

    function automatic logic in_span(input logic [31:0] p, input logic [31:0] lo,
                                     input logic [31:0] hi);
        in_span = (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/seg_digit_cell.sv
// One seven-segment glyph at a fixed origin; combinational pixel hit test.
module seg_digit_cell
    import seg_score_display_pkg::*;
#(
    parameter int unsigned HW      = 10,
    parameter int unsigned VW      = 10,
    parameter int unsigned X0      = 0,
    parameter int unsigned Y0      = 0,
    parameter int unsigned SEG_LEN = 20,
    parameter int unsigned SEG_THK = 4
) (
    input  logic [HW-1:0]    count_h,
    input  logic [VW-1:0]    count_v,
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic             hit
);

    localparam int unsigned XA = X0 + SEG_THK;
    localparam int unsigned XB = X0 + SEG_THK + SEG_LEN;
    localparam int unsigned XC = X0 + 2 * SEG_THK + SEG_LEN;
    localparam int unsigned YB = Y0 + SEG_THK;
    localparam int unsigned YC = Y0 + SEG_THK + SEG_LEN;
    localparam int unsigned YD = Y0 + 2 * SEG_THK + SEG_LEN;
    localparam int unsigned YE = Y0 + 2 * SEG_THK + 2 * SEG_LEN;
    localparam int unsigned YF = Y0 + 3 * SEG_THK + 2 * SEG_LEN;

    logic [31:0] x;
    logic [31:0] y;
    logic [6:0]  segs;
    logic        col_l, col_m, col_r;
    logic        row_top, row_up, row_mid, row_lo, row_bot;

    // Compare at 32 bits so coordinates past the counter range cannot alias.
    always_comb begin
        x       = 32'(count_h);
        y       = 32'(count_v);
        segs    = seg_lut(digit);
        col_l   = in_span(x, X0, XA);
        col_m   = in_span(x, XA, XB);
        col_r   = in_span(x, XB, XC);
        row_top = in_span(y, Y0, YB);
        row_up  = in_span(y, YB, YC);
        row_mid = in_span(y, YC, YD);
        row_lo  = in_span(y, YD, YE);
        row_bot = in_span(y, YE, YF);
        hit = !blank && (
              (segs[SEG_A] && col_m && row_top) ||
              (segs[SEG_B] && col_r && row_up)  ||
              (segs[SEG_C] && col_r && row_lo)  ||
              (segs[SEG_D] && col_m && row_bot) ||
              (segs[SEG_E] && col_l && row_lo)  ||
              (segs[SEG_F] && col_l && row_up)  ||
              (segs[SEG_G] && col_m && row_mid));
    end

endmodule

// File: rtl/seg_score_display.sv
// N-digit BCD score counter rendered as seven-segment glyphs from the VGA pixel counters.
module seg_score_display
    import seg_score_display_pkg::*;
#(
    parameter int unsigned H_TOT        = 800,
    parameter int unsigned V_TOT        = 525,
    parameter int unsigned POS_X        = 16,
    parameter int unsigned POS_Y        = 16,
    parameter int unsigned N_DIGITS     = 3,
    parameter int unsigned SEG_LEN      = 20,
    parameter int unsigned SEG_THK      = 4,
    parameter int unsigned DIGIT_GAP    = 8,
    parameter int unsigned LZ_BLANK     = 1,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic [$clog2(H_TOT)-1:0]    iCountH,
    input  logic [$clog2(V_TOT)-1:0]    iCountV,
    input  logic                        iFrameTick,
    input  logic                        iIncr,
    input  logic                        iClear,
    input  logic                        iEnable,
    output logic                        oDraw,
    output logic [BCD_W*N_DIGITS-1:0]   oScore,
    output logic                        oMaxed
);

    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    localparam int unsigned SW    = BCD_W * N_DIGITS;
    localparam int unsigned DIG_W = SEG_LEN + 2 * SEG_THK;
    localparam int unsigned BF_W  = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned BW    = (BF_W < 3) ? 3 : BF_W;

    logic [SW-1:0]       score;
    logic [SW-1:0]       disp_score;
    logic [BW-1:0]       blink_cnt;
    logic                maxed;
    logic                draw;
    logic [SW-1:0]       score_inc;
    logic                all_nines;
    logic                carry;
    logic [BCD_W-1:0]    nib;
    logic                accept;
    logic                suppress;
    logic                zero_run;
    logic [N_DIGITS-1:0] blank;
    logic [N_DIGITS-1:0] hit;

    // BCD ripple increment; nibble 0 (bits [3:0]) is the least significant digit.
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        all_nines = 1'b1;
        nib       = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            nib = score[i*BCD_W +: BCD_W];
            if (carry) begin
                if (nib == 4'd9) begin
                    nib = '0;
                end else begin
                    nib   = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            score_inc[i*BCD_W +: BCD_W] = nib;
            if (nib != 4'd9) all_nines = 1'b0;
        end
    end

    assign accept   = iIncr && !iClear && !maxed;
    assign suppress = (blink_cnt != '0) && blink_cnt[2];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            score      <= '0;
            maxed      <= 1'b0;
            disp_score <= '0;
            blink_cnt  <= '0;
        end else begin
            if (iClear) begin
                score <= '0;
                maxed <= 1'b0;
            end else if (accept) begin
                score <= score_inc;
                maxed <= all_nines;
            end
            if (iFrameTick) disp_score <= score;
            if (accept) begin
                blink_cnt <= BW'(BLINK_FRAMES);
            end else if (iFrameTick && blink_cnt != '0) begin
                blink_cnt <= blink_cnt - BW'(1);
            end
        end
    end

    // Digit k (k = 0 leftmost) is blank while it and every digit to its left are zero.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            zero_run = zero_run && (disp_score[BCD_W*(N_DIGITS-1-k) +: BCD_W] == 4'd0);
            blank[k] = (LZ_BLANK != 0) && (k + 1 < N_DIGITS) && zero_run;
        end
    end

    for (genvar k = 0; k < int'(N_DIGITS); k++) begin : g_digit
        seg_digit_cell #(
            .HW      (HW),
            .VW      (VW),
            .X0      (POS_X + k * (DIG_W + DIGIT_GAP)),
            .Y0      (POS_Y),
            .SEG_LEN (SEG_LEN),
            .SEG_THK (SEG_THK)
        ) u_cell (
            .count_h (iCountH),
            .count_v (iCountV),
            .digit   (disp_score[BCD_W*(N_DIGITS-1-k) +: BCD_W]),
            .blank   (blank[k]),
            .hit     (hit[k])
        );
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            draw <= 1'b0;
        end else begin
            draw <= iEnable && (|hit) && !suppress;
        end
    end

    assign oDraw  = draw;
    assign oScore = score;
    assign oMaxed = maxed;

endmodule

// File: tb/tb_seg_score_display.sv
// Directed bench for seg_score_display with a decimal/rectangle reference model.
module tb_seg_score_display;

    localparam int L = 20, T = 4, GAP = 8, PX = 16, PY = 16, N = 3, BF = 16;
    localparam int W = L + 2 * T;

    logic        clk, rst_n;
    logic [9:0]  ch, cv;
    logic        tick, incr, clear, en;
    logic        draw;
    logic [11:0] score;
    logic        maxed;

    int total = 0;
    int bad   = 0;
    int ones  = 0;
    bit cmp_on = 0;

    // Model state: plain integers, not BCD.
    int m_score, m_disp, m_blink;
    bit m_maxed, exp_draw;

    string segs_of[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    int rx0[7] = '{T, T + L, T + L, T, 0, 0, T};
    int rx1[7] = '{T + L, 2*T + L, 2*T + L, T + L, T, T, T + L};
    int ry0[7] = '{0, T, 2*T + L, 2*T + 2*L, 2*T + L, T, T + L};
    int ry1[7] = '{T, T + L, 2*T + 2*L, 3*T + 2*L, 2*T + 2*L, T + L, 2*T + L};

    seg_score_display dut (
        .iClk       (clk),
        .iRstN      (rst_n),
        .iCountH    (ch),
        .iCountV    (cv),
        .iFrameTick (tick),
        .iIncr      (incr),
        .iClear     (clear),
        .iEnable    (en),
        .oDraw      (draw),
        .oScore     (score),
        .oMaxed     (maxed)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int pow10(int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit lit(int d, int s);
        string p = segs_of[d];
        for (int i = 0; i < p.len(); i++)
            if (p[i] == 8'(97 + s)) return 1;
        return 0;
    endfunction

    function automatic bit model_pix(int h, int v, int disp, int blink, bit e);
        if (!e) return 0;
        if (blink != 0 && ((blink >> 2) & 1) == 1) return 0;
        for (int k = 0; k < N; k++) begin
            int place = pow10(N - 1 - k);
            int d = (disp / place) % 10;
            int lx = h - (PX + k * (W + GAP));
            int ly = v - PY;
            if (k < N - 1 && disp < place) continue;
            for (int s = 0; s < 7; s++)
                if (lit(d, s) && lx >= rx0[s] && lx < rx1[s] && ly >= ry0[s] && ly < ry1[s])
                    return 1;
        end
        return 0;
    endfunction

    function automatic logic [11:0] to_bcd(int n);
        logic [11:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((n / pow10(i)) % 10);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_score  <= 0;
            m_disp   <= 0;
            m_blink  <= 0;
            m_maxed  <= 0;
            exp_draw <= 0;
        end else begin
            exp_draw <= model_pix(int'(ch), int'(cv), m_disp, m_blink, en);
            if (tick) m_disp <= m_score;
            if (clear) begin
                m_score <= 0;
                m_maxed <= 0;
            end else if (incr && !m_maxed) begin
                m_score <= m_score + 1;
                m_maxed <= (m_score + 1 == pow10(N) - 1);
            end
            if (incr && !clear && !m_maxed) m_blink <= BF;
            else if (tick && m_blink > 0) m_blink <= m_blink - 1;
        end
    end

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_draw", draw, exp_draw);
            chk("cyc_score", score, to_bcd(m_score));
            chk("cyc_maxed", maxed, m_maxed);
        end
    end

    task automatic cyc(int h, int v, bit tk, bit inc, bit clr);
        ch = 10'(h); cv = 10'(v); tick = tk; incr = inc; clear = clr;
        @(posedge clk);
        #1;
        tick = 0; incr = 0; clear = 0;
    endtask

    task automatic pix(string name, int h, int v, bit exp);
        cyc(h, v, 0, 0, 0);
        chk(name, draw, exp);
    endtask

    task automatic sweep();
        for (int v = 10; v < 72; v += 3)
            for (int h = 10; h < 130; h += 3) begin
                cyc(h, v, 0, 0, 0);
                if (draw) ones++;
            end
    endtask

    task automatic count_to_42_quiet();
        cyc(0, 0, 0, 0, 1);
        repeat (42) cyc(0, 0, 0, 1, 0);
        repeat (17) cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        rst_n = 0; en = 1; ch = 0; cv = 0; tick = 0; incr = 0; clear = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_draw", draw, 0);
        chk("rst_score", score, 12'h000);
        chk("rst_maxed", maxed, 0);
        rst_n = 1;
        cmp_on = 1;

        // Score 000: only the rightmost digit shows.
        cyc(0, 0, 1, 0, 0);
        pix("d2_seg_a", 100, 17, 1);
        pix("d2_seg_g_off", 100, 42, 0);
        pix("d0_blanked", 30, 17, 0);
        pix("d1_blanked", 66, 17, 0);
        sweep();

        // Eight increments, then blink phases across frame ticks.
        repeat (8) cyc(0, 0, 0, 1, 0);
        chk("score_008", score, 12'h008);
        repeat (4) cyc(0, 0, 1, 0, 0);
        pix("blink_off_g", 100, 42, 0);
        pix("blink_off_a", 100, 17, 0);
        cyc(0, 0, 1, 0, 0);
        pix("eight_g_on", 100, 42, 1);
        sweep();

        // Saturation at 999.
        cyc(0, 0, 0, 0, 1);
        repeat (998) cyc(0, 0, 0, 1, 0);
        chk("maxed_at_998", maxed, 0);
        cyc(0, 0, 0, 1, 0);
        chk("maxed_at_999", maxed, 1);
        chk("score_999", score, 12'h999);
        cyc(0, 0, 0, 1, 0);
        chk("score_held", score, 12'h999);
        repeat (20) cyc(0, 0, 1, 0, 0);
        sweep();

        // Display latch: live score moves, glyph waits for the frame tick.
        count_to_42_quiet();
        pix("e_of_42", 89, 50, 1);
        cyc(0, 0, 0, 1, 0);
        chk("score_043_live", score, 12'h043);
        pix("still_42", 89, 50, 1);
        cyc(0, 0, 1, 1, 0);
        chk("score_044_live", score, 12'h044);
        pix("tick_incr_shows_43", 100, 17, 1);
        cyc(0, 0, 1, 0, 0);
        sweep();

        // Clear beats increment and loads no blink.
        count_to_42_quiet();
        chk("score_042", score, 12'h042);
        cyc(0, 0, 0, 1, 1);
        chk("clr_incr_score", score, 12'h000);
        chk("clr_incr_maxed", maxed, 0);
        cyc(0, 0, 1, 0, 0);
        pix("clr_no_blink", 100, 17, 1);

        // Asynchronous reset mid-frame.
        #2 rst_n = 0;
        #1;
        chk("async_rst_draw", draw, 0);
        chk("async_rst_score", score, 12'h000);
        @(posedge clk);
        #1 rst_n = 1;
        en = 0;
        ones = 0;
        sweep();
        chk("disabled_sweep", ones, 0);
        en = 1;
        cyc(0, 0, 1, 0, 0);
        sweep();

        cmp_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
